// File: rtl/dmem_pipe.sv
// dmem_pipe: byte-addressed data memory behind a valid/ready request port.
// Ports: clk/rst, req_* (request in), resp_* (response pulse), tohost_* (exit).
module dmem_pipe #(
  parameter int unsigned DMEM_SIZE   = 16384,
  parameter logic [63:0] DMEM_BASE   = 64'h8000_0000,
  parameter logic [63:0] TOHOST_ADDR = 64'h8000_1000,
  parameter int unsigned LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_exc_en,
  output logic [3:0]  resp_exc_code,
  output logic [63:0] resp_exc_val,
  output logic        tohost_written,
  output logic [63:0] tohost_data
);

  localparam int AW = $clog2(DMEM_SIZE);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [63:0] rdata_q, rdata_d;
  logic        exc_en_q, exc_en_d;
  logic [3:0]  exc_code_q, exc_code_d;
  logic [63:0] exc_val_q, exc_val_d;
  logic        toh_wr_q, toh_wr_d;
  logic [63:0] toh_data_q, toh_data_d;

  logic [7:0] mem [DMEM_SIZE] = '{default: 8'h00};

  logic          accept;
  logic [3:0]    nbytes;
  logic [2:0]    amask;
  logic [63:0]   offset;
  logic [64:0]   off_end;
  logic          acc_fault;
  logic          mis_fault;
  logic          fault;
  logic          is_tohost;
  logic          mem_we;
  logic [AW-1:0] base_idx;
  logic [63:0]   raw;
  logic [63:0]   ext;
  logic [3:0]    code;

  assign req_ready = (state_q == IDLE || state_q == RESP) && !rst;
  assign accept    = req_valid && req_ready;

  assign nbytes   = 4'd1 << req_size;
  assign amask    = 3'(nbytes - 4'd1);
  assign offset   = req_addr - DMEM_BASE;
  // 65-bit sum so an offset near 2^64 cannot wrap back into range
  assign off_end  = {1'b0, offset} + {61'd0, nbytes};
  assign base_idx = offset[AW-1:0];

  assign acc_fault = (req_addr < DMEM_BASE) || (off_end > 65'(DMEM_SIZE));
  assign mis_fault = !acc_fault && ((req_addr[2:0] & amask) != 3'd0);
  assign fault     = acc_fault || mis_fault;
  assign is_tohost = (req_addr == TOHOST_ADDR);
  assign mem_we    = accept && req_we && !fault && !is_tohost;

  always_comb begin
    raw = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < int'(nbytes)) begin
        raw[8*i +: 8] = mem[base_idx + AW'(i)];
      end
    end
  end

  always_comb begin
    ext = raw;
    case (req_size)
      2'd0: ext = req_unsigned ? {56'd0, raw[7:0]}
                               : {{56{raw[7]}}, raw[7:0]};
      2'd1: ext = req_unsigned ? {48'd0, raw[15:0]}
                               : {{48{raw[15]}}, raw[15:0]};
      2'd2: ext = req_unsigned ? {32'd0, raw[31:0]}
                               : {{32{raw[31]}}, raw[31:0]};
      default: ext = raw;
    endcase
  end

  always_comb begin
    code = 4'd0;
    unique case (1'b1)
      acc_fault: code = req_we ? 4'd7 : 4'd5;
      mis_fault: code = req_we ? 4'd6 : 4'd4;
      default:   code = 4'd0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    exc_en_d   = exc_en_q;
    exc_code_d = exc_code_q;
    exc_val_d  = exc_val_q;
    toh_wr_d   = toh_wr_q;
    toh_data_d = toh_data_q;
    unique case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          state_d    = (LATENCY == 1) ? RESP : WAIT;
          cnt_d      = 2'(LATENCY - 1);
          rdata_d    = (fault || req_we) ? 64'd0 : ext;
          exc_en_d   = fault;
          exc_code_d = code;
          exc_val_d  = fault ? req_addr : 64'd0;
          if (req_we && !fault && is_tohost) begin
            toh_wr_d   = 1'b1;
            toh_data_d = req_wdata;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == 2'd1) begin
          state_d = RESP;
          cnt_d   = 2'd0;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      rdata_q    <= 64'd0;
      exc_en_q   <= 1'b0;
      exc_code_q <= 4'd0;
      exc_val_q  <= 64'd0;
      toh_wr_q   <= 1'b0;
      toh_data_q <= 64'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      exc_en_q   <= exc_en_d;
      exc_code_q <= exc_code_d;
      exc_val_q  <= exc_val_d;
      toh_wr_q   <= toh_wr_d;
      toh_data_q <= toh_data_d;
    end
  end

  // Stores commit at acceptance; reset never touches the array.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 8; i++) begin
        if (i < int'(nbytes)) begin
          mem[base_idx + AW'(i)] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

  assign resp_valid     = (state_q == RESP);
  assign resp_rdata     = resp_valid ? rdata_q    : 64'd0;
  assign resp_exc_en    = resp_valid ? exc_en_q   : 1'b0;
  assign resp_exc_code  = resp_valid ? exc_code_q : 4'd0;
  assign resp_exc_val   = resp_valid ? exc_val_q  : 64'd0;
  assign tohost_written = toh_wr_q;
  assign tohost_data    = toh_data_q;

endmodule
